// File: rtl/single_port_ram.sv
// Synchronous single-port RAM: one shared address, synchronous write-first write,
// registered read with one cycle of latency and a synchronous reset of the output register only.
module single_port_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 64
) (
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] ram_address,
    input  logic                  write_enable,
    input  logic                  clk,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  rst
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_out_q;

    // Storage is deliberately left out of reset so the array maps onto block RAM.
    // A reset edge also suppresses any write that arrives on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_q <= '0;
        end else if (write_enable) begin
            mem[ram_address] <= data_in;
            data_out_q       <= data_in;
        end else begin
            data_out_q <= mem[ram_address];
        end
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_single_port_ram.sv
// Bench for single_port_ram: a table of directed vectors followed by randomized
// traffic, checked against an associative-array memory model.
module tb_single_port_ram;

    logic [7:0] data_in;
    logic [5:0] ram_address;
    logic       write_enable;
    logic       clk;
    logic [7:0] data_out;
    logic       rst;

    int n_cmp = 0;
    int n_err = 0;

    single_port_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .DEPTH(64)) dut (
        .data_in      (data_in),
        .ram_address  (ram_address),
        .write_enable (write_enable),
        .clk          (clk),
        .data_out     (data_out),
        .rst          (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       we;
        logic [5:0] addr;
        logic [7:0] din;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic w, input logic [5:0] a,
                                input logic [7:0] d, input logic [7:0] e, input string n);
        vec_t v;
        v.rst = r; v.we = w; v.addr = a; v.din = d; v.exp = e; v.name = n;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [5:0] a, input logic [7:0] d);
        rst = r; write_enable = w; ram_address = a; data_in = d;
        @(posedge clk);
        #1;
    endtask

    // The model records only what the random phase has written.
    logic [7:0] model [int];
    logic [7:0] last_exp;
    bit         last_known;

    initial begin
        rst = 1'b1; write_enable = 1'b0; ram_address = '0; data_in = '0;

        // Reset must win over a concurrent write request.
        vecs.push_back(mk(1, 1, 6'd5,  8'hFF, 8'h00, "reset_edge0"));
        vecs.push_back(mk(1, 1, 6'd5,  8'hFF, 8'h00, "reset_edge1"));
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].we, vecs[i].addr, vecs[i].din);
            chk(vecs[i].name, data_out, vecs[i].exp);
        end

        drive(0, 0, 6'd5, 8'h00);
        n_cmp++;
        if (data_out === 8'hFF) begin
            n_err++;
            $display("FAIL reset_blocks_write: got %h expected anything but ff", data_out);
        end

        vecs.delete();
        vecs.push_back(mk(0, 1, 6'd0,  8'h10, 8'h10, "write0"));
        vecs.push_back(mk(0, 1, 6'd2,  8'h11, 8'h11, "write2"));
        vecs.push_back(mk(0, 1, 6'd7,  8'hAF, 8'hAF, "write7"));
        vecs.push_back(mk(0, 0, 6'd0,  8'h00, 8'h10, "read0"));
        vecs.push_back(mk(0, 0, 6'd2,  8'h00, 8'h11, "read2"));
        vecs.push_back(mk(0, 0, 6'd7,  8'h00, 8'hAF, "read7"));
        vecs.push_back(mk(0, 1, 6'd63, 8'h5A, 8'h5A, "write63"));
        vecs.push_back(mk(0, 1, 6'd0,  8'hC3, 8'hC3, "write0_b"));
        vecs.push_back(mk(0, 0, 6'd63, 8'h00, 8'h5A, "read63"));
        vecs.push_back(mk(0, 0, 6'd0,  8'h00, 8'hC3, "read0_b"));
        vecs.push_back(mk(0, 1, 6'd9,  8'h77, 8'h77, "write9"));
        vecs.push_back(mk(1, 1, 6'd9,  8'hEE, 8'h00, "mid_reset"));
        vecs.push_back(mk(0, 0, 6'd9,  8'h00, 8'h77, "read9_retained"));
        vecs.push_back(mk(0, 1, 6'd3,  8'h01, 8'h01, "overwrite_a"));
        vecs.push_back(mk(0, 1, 6'd3,  8'h02, 8'h02, "overwrite_b"));
        vecs.push_back(mk(0, 0, 6'd3,  8'h00, 8'h02, "read3"));
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].we, vecs[i].addr, vecs[i].din);
            chk(vecs[i].name, data_out, vecs[i].exp);
        end

        // Randomized traffic; only reads of addresses written in this phase are checked.
        last_exp = 8'h02; last_known = 1'b1;
        for (int n = 0; n < 600; n++) begin
            logic       r, w;
            logic [5:0] a;
            logic [7:0] d;
            r = ($urandom_range(0, 15) == 0);
            w = $urandom_range(0, 1);
            a = (n % 7 == 0) ? 6'($urandom_range(0, 1) * 63) : 6'($urandom_range(0, 63));
            d = 8'($urandom);
            rst = r; write_enable = w; ram_address = a; data_in = d;
            #2;
            // Changing inputs mid-cycle must not disturb the registered output.
            if (last_known) chk("rand_hold", data_out, last_exp);
            @(posedge clk);
            #1;
            if (r) begin
                last_exp = 8'h00; last_known = 1'b1;
            end else if (w) begin
                model[a] = d;
                last_exp = d; last_known = 1'b1;
            end else if (model.exists(a)) begin
                last_exp = model[a]; last_known = 1'b1;
            end else begin
                last_known = 1'b0;
            end
            if (last_known) chk("rand_out", data_out, last_exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
